// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 registers operands/opcode, stage 2 computes and
// registers result and flags; valid/ready handshakes on both sides with an internal accumulator.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int OP_LEN = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [OP_LEN-1:0] opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              cout,
  output logic              negative,
  output logic              overflow,
  output logic              zero,
  output logic              illegal
);

  localparam logic [OP_LEN-1:0] OP_ADD = OP_LEN'(1);
  localparam logic [OP_LEN-1:0] OP_NEG = OP_LEN'(2);
  localparam logic [OP_LEN-1:0] OP_SUB = OP_LEN'(3);
  localparam logic [OP_LEN-1:0] OP_ACC = OP_LEN'(4);
  localparam logic [OP_LEN-1:0] OP_CLR = OP_LEN'(5);
  localparam logic [WIDTH-1:0]  MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic             il;
  } alu_res_t;

  logic signed [WIDTH-1:0]  a_p1;
  logic signed [WIDTH-1:0]  b_p1;
  logic        [OP_LEN-1:0] op_p1;
  logic                     vld_p1;
  logic signed [WIDTH-1:0]  acc;
  logic                     adv;
  alu_res_t                 res_p1;

  function automatic logic [WIDTH:0] add_c(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  endfunction

  // Signed overflow of x+y: operands agree in sign and the sum does not.
  function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic alu_res_t alu_op(input logic [OP_LEN-1:0] op,
                                      input logic [WIDTH-1:0]  x,
                                      input logic [WIDTH-1:0]  y,
                                      input logic [WIDTH-1:0]  acc_v);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] t;
    alu_res_t         o;
    s = '0;
    t = '0;
    o = '0;
    case (op)
      OP_ADD: begin
        s   = add_c(x, y, 1'b0);
        o.r = s[WIDTH-1:0];
        o.c = s[WIDTH];
        o.v = add_ovf(x, y, o.r);
      end
      OP_NEG: begin
        t   = x + y;
        s   = add_c(~t, '0, 1'b1);
        o.r = s[WIDTH-1:0];
        o.c = s[WIDTH];
        o.v = (t == MIN_VAL);
      end
      OP_SUB: begin
        s   = add_c(x, ~y, 1'b1);
        o.r = s[WIDTH-1:0];
        o.c = s[WIDTH];
        o.v = (x[WIDTH-1] != y[WIDTH-1]) && (o.r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_ACC: begin
        s   = add_c(acc_v, x, 1'b0);
        o.r = s[WIDTH-1:0];
        o.c = s[WIDTH];
        o.v = add_ovf(acc_v, x, o.r);
      end
      OP_CLR:  o = '0;
      default: o.il = 1'b1;
    endcase
    return o;
  endfunction

  assign adv      = vld_p1 && (!out_valid || out_ready);
  assign in_ready = !vld_p1 || adv;

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_p1  <= a;
      b_p1  <= b;
      op_p1 <= opcode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_valid && in_ready) begin
      vld_p1 <= 1'b1;
    end else if (adv) begin
      vld_p1 <= 1'b0;
    end
  end

  always_comb begin
    res_p1 = alu_op(op_p1, a_p1, b_p1, acc);
  end

  // Stage 2: compute, register result/flags, update accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      acc       <= '0;
    end else if (adv) begin
      out_valid <= 1'b1;
      result    <= res_p1.r;
      cout      <= res_p1.c;
      negative  <= res_p1.r[WIDTH-1];
      overflow  <= res_p1.v;
      zero      <= (res_p1.r == '0);
      illegal   <= res_p1.il;
      if (op_p1 == OP_ACC) begin
        acc <= res_p1.r;
      end else if (op_p1 == OP_CLR) begin
        acc <= '0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed corner vectors, streaming with stalls, randomized traffic
// against a plain-arithmetic reference model, and reset with operations in flight.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int OL = 5;
  localparam longint MAXS = 64'sh7FFF_FFFF;
  localparam longint MINS = -64'sh8000_0000;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         n;
    logic         v;
    logic         z;
    logic         il;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [OL-1:0] opcode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          cout, negative, overflow, zero, illegal;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] m_acc = '0;
  res_t         exp_q[$];

  logic [OL-1:0] t_op [17] = '{5'd1, 5'd1, 5'd3, 5'd2, 5'd2, 5'd2, 5'd3, 5'd3, 5'd5,
                               5'd4, 5'd4, 5'd4, 5'd7, 5'd0, 5'd31, 5'd4, 5'd1};
  logic [W-1:0]  t_a  [17] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h5, 32'h3, 32'h80000000, 32'h0,
                               32'h7, 32'h80000000, 32'h12345, 32'hA, 32'h5, 32'h0, 32'h0,
                               32'h0, 32'h0, 32'hFFFFFFF1, 32'h80000000};
  logic [W-1:0]  t_b  [17] = '{32'h1, 32'h1, 32'h7, 32'h2, 32'h0, 32'h0, 32'h7, 32'h1,
                               32'h6789, 32'hFFFF, 32'hFFFF, 32'h0, 32'h5, 32'h5, 32'h5,
                               32'h0, 32'h80000000};
  logic [W-1:0]  t_r  [17] = '{32'h0, 32'h80000000, 32'hFFFFFFFE, 32'hFFFFFFFB, 32'h80000000,
                               32'h0, 32'h0, 32'h7FFFFFFF, 32'h0, 32'hA, 32'hF, 32'hF, 32'h0,
                               32'h0, 32'h0, 32'h0, 32'h0};
  // {cout, negative, overflow, zero, illegal}
  logic [4:0]    t_f  [17] = '{5'b10010, 5'b01100, 5'b01000, 5'b01000, 5'b01100, 5'b10010,
                               5'b10010, 5'b10100, 5'b00010, 5'b00000, 5'b00000, 5'b00000,
                               5'b00011, 5'b00011, 5'b00011, 5'b10010, 5'b10110};

  alu_pipe #(.WIDTH(W), .OP_LEN(OL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .negative  (negative),
    .overflow  (overflow),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic res_t observe();
    return {result, cout, negative, overflow, zero, illegal};
  endfunction

  // Reference: unsigned results from wide arithmetic, overflow from signed range checks.
  function automatic res_t model(input logic [OL-1:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    res_t         e;
    logic [63:0]  u;
    longint       sr;
    logic [W-1:0] s, p, q;
    e = '0;
    case (op)
      5'd1, 5'd4: begin
        p  = (op == 5'd4) ? m_acc : x;
        q  = (op == 5'd4) ? x : y;
        u  = {32'd0, p} + {32'd0, q};
        e.r = u[W-1:0];
        e.c = u[W];
        sr  = longint'(signed'(p)) + longint'(signed'(q));
        e.v = (sr > MAXS) || (sr < MINS);
        if (op == 5'd4) m_acc = e.r;
      end
      5'd2: begin
        s   = x + y;
        e.r = 32'd0 - s;
        e.c = (s == 32'd0);
        sr  = -longint'(signed'(s));
        e.v = (sr > MAXS);
      end
      5'd3: begin
        e.r = x - y;
        e.c = (x >= y);
        sr  = longint'(signed'(x)) - longint'(signed'(y));
        e.v = (sr > MAXS) || (sr < MINS);
      end
      5'd5: m_acc = '0;
      default: e.il = 1'b1;
    endcase
    e.n = e.r[W-1];
    e.z = (e.r == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd32();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [OL-1:0] rnd_op();
    if ($urandom_range(9) < 8) return OL'($urandom_range(1, 5));
    return OL'($urandom_range(0, 31));
  endfunction

  // Issue one op with out_ready=1; return the first output seen and its latency in cycles.
  task automatic run_op(input logic [OL-1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output res_t o, output int lat);
    int k;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; a = x; b = y; out_ready = 1'b1;
    #4;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); #4; k++; end
    lat = -1;
    o   = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      if (out_valid) begin lat = i; o = observe(); break; end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready, observe()} !== {1'b0, 1'b1, 37'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got vld=%b rdy=%b res=%h, expected vld=0 rdy=1 res=0",
               out_valid, in_ready, observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_release: got vld=%b rdy=%b, expected vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    res_t o, e;
    int   lat;
    for (int i = 0; i < 17; i++) begin
      e = model(t_op[i], t_a[i], t_b[i]);
      run_op(t_op[i], t_a[i], t_b[i], o, lat);
      n_checks++;
      if (o !== {t_r[i], t_f[i]}) begin
        n_fail++;
        $display("FAIL directed_%0d op=%0d a=%h b=%h: got %h expected %h",
                 i, t_op[i], t_a[i], t_b[i], o, {t_r[i], t_f[i]});
      end
      n_checks++;
      if (lat !== 2) begin
        n_fail++;
        $display("FAIL latency_%0d: got %0d cycles expected 2", i, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [OL-1:0] ops [4] = '{5'd5, 5'd4, 5'd4, 5'd4};
    logic [W-1:0]  as  [4] = '{32'd99, 32'd10, 32'd5, 32'd0};
    logic [W-1:0]  exr [4] = '{32'd0, 32'd10, 32'd15, 32'd15};
    int            cyc_at [4];
    int            got;
    res_t          e;
    got = 0;
    out_ready = 1'b1;
    fork
      begin
        int k;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          in_valid = 1'b1; opcode = ops[i]; a = as[i]; b = $urandom();
          #4;
          k = 0;
          while (!in_ready && k < 50) begin @(negedge clk); #4; k++; end
          exp_q.push_back(model(opcode, a, b));
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
          @(negedge clk);
          #4;
          if (out_valid) begin
            cyc_at[got] = cyc;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_checks++;
            if (observe() !== e) begin
              n_fail++;
              $display("FAIL b2b_model_%0d: got %h expected %h", got, observe(), e);
            end
            n_checks++;
            if (result !== exr[got]) begin
              n_fail++;
              $display("FAIL b2b_acc_%0d: got %h expected %h", got, result, exr[got]);
            end
            got++;
          end
        end
      end
    join
    n_checks++;
    if (got !== 4 || cyc_at[3] - cyc_at[0] !== 3) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d outputs over %0d cycles, expected 4 over 3",
               got, (got == 4) ? cyc_at[3] - cyc_at[0] : -1);
    end
  endtask

  task automatic test_stall();
    int got, stall;
    got = 0;
    stall = 0;
    fork
      begin
        int k;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          in_valid = 1'b1; opcode = 5'd1; a = rnd32(); b = rnd32();
          #4;
          k = 0;
          while (!in_ready && k < 50) begin @(negedge clk); #4; k++; end
          exp_q.push_back(model(opcode, a, b));
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        res_t prev, e;
        logic held;
        held = 1'b0;
        prev = '0;
        for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
          @(negedge clk);
          out_ready = !(got == 2 && stall < 4);
          if (!out_ready) stall++;
          #4;
          if (held) begin
            n_checks++;
            if ({out_valid, observe()} !== {1'b1, prev}) begin
              n_fail++;
              $display("FAIL stall_hold: got vld=%b %h expected vld=1 %h", out_valid, observe(), prev);
            end
          end
          if (!out_ready) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
              n_fail++;
              $display("FAIL stall_in_ready: got %b expected 0", in_ready);
            end
          end
          held = out_valid && !out_ready;
          prev = observe();
          if (out_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_checks++;
            if (observe() !== e) begin
              n_fail++;
              $display("FAIL stall_order_%0d: got %h expected %h", got, observe(), e);
            end
            got++;
          end
        end
      end
    join
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    n_checks++;
    if (got !== 6 || stall !== 4 || exp_q.size() !== 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_count: got %0d outputs, %0d stalls, %0d pending, vld=%b expected 6,4,0,0",
               got, stall, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_random();
    int got;
    got = 0;
    fork
      begin
        int k, gap;
        for (int i = 0; i < 300; i++) begin
          gap = ($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0;
          repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
          @(negedge clk);
          in_valid = 1'b1; opcode = rnd_op(); a = rnd32(); b = rnd32();
          #4;
          k = 0;
          while (!in_ready && k < 100) begin @(negedge clk); #4; k++; end
          exp_q.push_back(model(opcode, a, b));
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        res_t prev, e;
        logic held;
        held = 1'b0;
        prev = '0;
        for (int cyc = 0; cyc < 6000 && got < 300; cyc++) begin
          @(negedge clk);
          out_ready = ($urandom_range(9) < 6);
          #4;
          if (held) begin
            n_checks++;
            if ({out_valid, observe()} !== {1'b1, prev}) begin
              n_fail++;
              $display("FAIL rand_hold: got vld=%b %h expected vld=1 %h", out_valid, observe(), prev);
            end
          end
          held = out_valid && !out_ready;
          prev = observe();
          if (out_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_checks++;
            if (observe() !== e) begin
              n_fail++;
              $display("FAIL rand_%0d: got %h expected %h", got, observe(), e);
            end
            got++;
          end
        end
      end
    join
    n_checks++;
    if (got !== 300) begin
      n_fail++;
      $display("FAIL rand_count: got %0d outputs expected 300", got);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    res_t o;
    int   lat, extra;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; opcode = 5'd4; a = 32'd7; b = '0;
    @(negedge clk);
    a = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_setup: got vld=%b rdy=%b expected vld=1 rdy=0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, observe()} !== {1'b0, 1'b1, 37'd0}) begin
      n_fail++;
      $display("FAIL midflight_reset: got vld=%b rdy=%b res=%h expected vld=0 rdy=1 res=0",
               out_valid, in_ready, observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = '0;
    exp_q.delete();
    out_ready = 1'b1;
    extra = 0;
    repeat (4) begin @(negedge clk); #4; if (out_valid) extra++; end
    run_op(5'd4, 32'd0, 32'd0, o, lat);
    n_checks++;
    if (o !== model(5'd4, 32'd0, 32'd0) || lat !== 2) begin
      n_fail++;
      $display("FAIL midflight_first_op: got %h lat=%0d expected %h lat=2",
               o, lat, {32'd0, 5'b00010});
    end
    repeat (4) begin @(negedge clk); #4; if (out_valid) extra++; end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL midflight_extra: got %0d spurious outputs expected 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
